// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC post-processing blocks.
// Phase scaling is pi = 2^XY_WDT, i.e. 2pi = 2^(PH_WDT-1).
package cordic_pkg;

  typedef enum logic [0:0] {
    NOPREV = 1'b0,
    TRACK  = 1'b1
  } ph_state_t;

  function automatic int ph_wdt_of(input int xy_wdt);
    return xy_wdt + 2;
  endfunction

  function automatic int two_pi_log2_of(input int xy_wdt);
    return xy_wdt + 1;
  endfunction

  function automatic longint pi_of(input int xy_wdt);
    return longint'(1) << xy_wdt;
  endfunction

endpackage

// File: rtl/cordic_ph_wrap.sv
// Combinational wrapped phase subtractor: dph = ph_a - ph_b folded into [-pi, pi).
// A difference of exactly +pi comes out as -pi.
module cordic_ph_wrap
  import cordic_pkg::*;
#(
  parameter int PH_WDT = 20
) (
  input  logic signed [PH_WDT-1:0] ph_a,
  input  logic signed [PH_WDT-1:0] ph_b,
  output logic signed [PH_WDT-1:0] dph
);

  logic signed [PH_WDT:0] d_full;
  logic                   unused_d_hi;

  // Keeping only the bits below 2pi is the modulo-2pi fold; the top bits are redundant.
  always_comb begin
    d_full = {ph_a[PH_WDT-1], ph_a} - {ph_b[PH_WDT-1], ph_b};
    dph    = {d_full[PH_WDT-2], d_full[PH_WDT-2:0]};
  end

  assign unused_d_hi = ^d_full[PH_WDT:PH_WDT-1];

endmodule

// File: rtl/cordic_fm_demod.sv
// Instantaneous-frequency estimator: wrapped phase increments of squelch-qualified
// CORDIC samples, averaged over blocks of 2^DEC_LOG2 samples.
module cordic_fm_demod
  import cordic_pkg::*;
#(
  parameter int  XY_WDT   = 18,
  parameter int  DEC_LOG2 = 2,
  localparam int PH_WDT   = ph_wdt_of(XY_WDT)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sclr,
  input  logic                     en,
  input  logic                     rdy,
  input  logic        [XY_WDT-1:0] mag,
  input  logic signed [PH_WDT-1:0] ph,
  input  logic        [XY_WDT-1:0] sq_thr,
  output logic                     fvld,
  output logic signed [PH_WDT-1:0] freq,
  output logic                     fsq
);

  localparam int              ACC_W    = PH_WDT + DEC_LOG2;
  localparam int              CNT_W    = (DEC_LOG2 > 0) ? DEC_LOG2 : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << DEC_LOG2) - 1);

  logic                     s1_vld_q, s1_vld_d;
  logic signed [PH_WDT-1:0] s1_ph_q, s1_ph_d;
  logic                     s1_sq_q, s1_sq_d;

  ph_state_t                state_q, state_d;
  logic signed [PH_WDT-1:0] ph_prev_q, ph_prev_d;
  logic                     s2_vld_q, s2_vld_d;
  logic signed [PH_WDT-1:0] s2_dph_q, s2_dph_d;
  logic                     s2_sq_q, s2_sq_d;

  logic        [CNT_W-1:0]  cnt_q, cnt_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic                     sqacc_q, sqacc_d;

  logic signed [PH_WDT-1:0] freq_q, freq_d;
  logic                     fsq_q, fsq_d;
  logic                     fvld_q, fvld_d;

  logic signed [PH_WDT-1:0] wrap_dph;
  logic signed [ACC_W-1:0]  dph_ext;
  logic signed [ACC_W-1:0]  acc_sum;
  logic signed [ACC_W-1:0]  acc_shift;
  logic                     sq_sum;

  cordic_ph_wrap #(
    .PH_WDT(PH_WDT)
  ) u_ph_wrap (
    .ph_a (s1_ph_q),
    .ph_b (ph_prev_q),
    .dph  (wrap_dph)
  );

  // sclr beats everything; en low freezes state but still lets fvld fall.
  always_comb begin
    s1_vld_d  = s1_vld_q;
    s1_ph_d   = s1_ph_q;
    s1_sq_d   = s1_sq_q;
    state_d   = state_q;
    ph_prev_d = ph_prev_q;
    s2_vld_d  = s2_vld_q;
    s2_dph_d  = s2_dph_q;
    s2_sq_d   = s2_sq_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    sqacc_d   = sqacc_q;
    freq_d    = freq_q;
    fsq_d     = fsq_q;
    fvld_d    = 1'b0;
    dph_ext   = ACC_W'(s2_dph_q);
    acc_sum   = (cnt_q == '0) ? dph_ext : acc_q + dph_ext;
    sq_sum    = (cnt_q == '0) ? s2_sq_q : (sqacc_q | s2_sq_q);
    acc_shift = acc_sum >>> DEC_LOG2;

    if (sclr) begin
      s1_vld_d  = 1'b0;
      s1_ph_d   = '0;
      s1_sq_d   = 1'b0;
      state_d   = NOPREV;
      ph_prev_d = '0;
      s2_vld_d  = 1'b0;
      s2_dph_d  = '0;
      s2_sq_d   = 1'b0;
      cnt_d     = '0;
      acc_d     = '0;
      sqacc_d   = 1'b0;
      freq_d    = '0;
      fsq_d     = 1'b0;
    end else if (en) begin
      s1_vld_d = rdy;
      if (rdy) begin
        s1_ph_d = ph;
        s1_sq_d = (mag < sq_thr);
      end

      // A squelched sample, or one with no trusted predecessor, contributes zero.
      s2_vld_d = s1_vld_q;
      if (s1_vld_q) begin
        s2_dph_d  = (s1_sq_q || (state_q == NOPREV)) ? '0 : wrap_dph;
        s2_sq_d   = s1_sq_q;
        ph_prev_d = s1_ph_q;
        state_d   = s1_sq_q ? NOPREV : TRACK;
      end

      if (s2_vld_q) begin
        acc_d   = acc_sum;
        sqacc_d = sq_sum;
        if (cnt_q == CNT_LAST) begin
          cnt_d  = '0;
          freq_d = PH_WDT'(acc_shift);
          fsq_d  = sq_sum;
          fvld_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_vld_q  <= 1'b0;
      s1_ph_q   <= '0;
      s1_sq_q   <= 1'b0;
      state_q   <= NOPREV;
      ph_prev_q <= '0;
      s2_vld_q  <= 1'b0;
      s2_dph_q  <= '0;
      s2_sq_q   <= 1'b0;
      cnt_q     <= '0;
      acc_q     <= '0;
      sqacc_q   <= 1'b0;
      freq_q    <= '0;
      fsq_q     <= 1'b0;
      fvld_q    <= 1'b0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_ph_q   <= s1_ph_d;
      s1_sq_q   <= s1_sq_d;
      state_q   <= state_d;
      ph_prev_q <= ph_prev_d;
      s2_vld_q  <= s2_vld_d;
      s2_dph_q  <= s2_dph_d;
      s2_sq_q   <= s2_sq_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      sqacc_q   <= sqacc_d;
      freq_q    <= freq_d;
      fsq_q     <= fsq_d;
      fvld_q    <= fvld_d;
    end
  end

  assign fvld = fvld_q;
  assign freq = freq_q;
  assign fsq  = fsq_q;

endmodule

// File: tb/tb_cordic_fm_demod.sv
// Scoreboard bench for cordic_fm_demod: a plain-arithmetic frequency model queues
// expected block results, and a negedge monitor compares them as fvld pulses arrive.
module tb_cordic_fm_demod;

  localparam int XY_WDT   = 18;
  localparam int DEC_LOG2 = 2;
  localparam int PH_WDT   = XY_WDT + 2;
  localparam int PI       = 262144;
  localparam int TWO_PI   = 2 * PI;
  localparam int BLK      = 1 << DEC_LOG2;
  localparam int THR      = 1000;

  logic                     clk;
  logic                     reset;
  logic                     sclr;
  logic                     en;
  logic                     rdy;
  logic        [XY_WDT-1:0] mag;
  logic signed [PH_WDT-1:0] ph;
  logic        [XY_WDT-1:0] sq_thr;
  logic                     fvld;
  logic signed [PH_WDT-1:0] freq;
  logic                     fsq;

  typedef struct {
    int freq;
    bit fsq;
    int due;
  } exp_t;

  exp_t sbq[$];
  exp_t cur;

  int checks = 0;
  int passes = 0;
  int en_edges = 0;
  int held_freq = 0;
  bit held_fsq = 1'b0;

  int prev_ph = 0;
  bit prev_valid = 1'b0;
  int blk_sum = 0;
  bit blk_sq = 1'b0;
  int blk_cnt = 0;

  cordic_fm_demod #(
    .XY_WDT   (XY_WDT),
    .DEC_LOG2 (DEC_LOG2)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .sclr   (sclr),
    .en     (en),
    .rdy    (rdy),
    .mag    (mag),
    .ph     (ph),
    .sq_thr (sq_thr),
    .fvld   (fvld),
    .freq   (freq),
    .fsq    (fsq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Phase difference folded into [-pi, pi) by modular arithmetic.
  function automatic int wrapDiff(input int a, input int b);
    int m;
    m = (a - b) % TWO_PI;
    if (m < 0) m += TWO_PI;
    if (m >= PI) m -= TWO_PI;
    return m;
  endfunction

  function automatic int floorDiv(input int s);
    int q;
    q = s / BLK;
    if (s < 0 && q * BLK != s) q--;
    return q;
  endfunction

  task automatic modelClear();
    prev_valid = 1'b0;
    prev_ph    = 0;
    blk_sum    = 0;
    blk_sq     = 1'b0;
    blk_cnt    = 0;
    held_freq  = 0;
    held_fsq   = 1'b0;
    sbq.delete();
  endtask

  task automatic modelAccept(input int p, input bit sq);
    int   dph;
    exp_t e;
    dph = (sq || !prev_valid) ? 0 : wrapDiff(p, prev_ph);
    prev_ph    = p;
    prev_valid = !sq;
    blk_sum += dph;
    blk_sq  |= sq;
    blk_cnt++;
    if (blk_cnt == BLK) begin
      e.freq = floorDiv(blk_sum);
      e.fsq  = blk_sq;
      e.due  = en_edges + 2;
      sbq.push_back(e);
      blk_sum = 0;
      blk_sq  = 1'b0;
      blk_cnt = 0;
    end
  endtask

  // One clock of stimulus; the model follows what the DUT sees at the edge.
  task automatic applyStimulus(input bit r, input int p, input int m, input bit e, input bit s);
    logic signed [PH_WDT-1:0] pt;
    pt   = p[PH_WDT-1:0];
    rdy  = r;
    ph   = pt;
    mag  = m[XY_WDT-1:0];
    en   = e;
    sclr = s;
    @(posedge clk);
    if (s) begin
      modelClear();
    end else if (e) begin
      en_edges++;
      if (r) modelAccept(int'(pt), m < THR);
    end
    #1;
  endtask

  task automatic sendRamp(input int start, input int step, input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b1, start + k * step, 50000, 1'b1, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 0, 50000, 1'b1, 1'b0);
  endtask

  // Monitor: every fvld pops one expectation; otherwise outputs must hold.
  always @(negedge clk) begin
    if (reset) begin
      if (fvld) begin
        if (sbq.size() == 0) begin
          checkOutput("fvld_unexpected", int'(fvld), 0);
        end else begin
          cur = sbq.pop_front();
          checkOutput("freq", int'(freq), cur.freq);
          checkOutput("fsq", int'(fsq), int'(cur.fsq));
          checkOutput("latency", en_edges, cur.due);
          held_freq = cur.freq;
          held_fsq  = cur.fsq;
        end
      end else begin
        checkOutput("freq_hold", int'(freq), held_freq);
        checkOutput("fsq_hold", int'(fsq), int'(held_fsq));
        if (sbq.size() > 0 && en_edges > sbq[0].due) begin
          void'(sbq.pop_front());
          checkOutput("fvld_timely", int'(fvld), 1);
        end
      end
    end
  end

  initial begin
    #200us;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset  = 1'b0;
    sq_thr = XY_WDT'(THR);
    sclr   = 1'b0;
    en     = 1'b1;
    rdy    = 1'b0;
    mag    = '0;
    ph     = '0;

    for (int k = 0; k < 4; k++) begin
      rdy  = 1'($urandom_range(0, 1));
      en   = 1'($urandom_range(0, 1));
      sclr = 1'($urandom_range(0, 1));
      ph   = PH_WDT'($urandom);
      mag  = XY_WDT'($urandom);
      @(posedge clk);
      #1;
      checkOutput("reset_fvld", int'(fvld), 0);
      checkOutput("reset_freq", int'(freq), 0);
      checkOutput("reset_fsq", int'(fsq), 0);
    end
    rdy   = 1'b0;
    sclr  = 1'b0;
    en    = 1'b1;
    reset = 1'b1;
    modelClear();
    idle(2);

    // Ramp after reset: expected 750 then 1000.
    sendRamp(0, 1000, 8);
    idle(5);

    // Wrap cases, 8 samples each so the second block is all one step.
    sendRamp(250000, -500000, 8);
    sendRamp(0, -262144, 8);
    sendRamp(-131072, 262144, 8);
    idle(5);

    // Squelch on sample 2 of the second block.
    sendRamp(0, 1000, 4);
    applyStimulus(1'b1, 4000, 50000, 1'b1, 1'b0);
    applyStimulus(1'b1, 5000, 100, 1'b1, 1'b0);
    applyStimulus(1'b1, 6000, 50000, 1'b1, 1'b0);
    applyStimulus(1'b1, 7000, 50000, 1'b1, 1'b0);
    idle(5);

    // Enable dropped for 5 cycles mid-block with rdy still asserted.
    sendRamp(10000, 3000, 6);
    for (int k = 0; k < 5; k++) applyStimulus(1'b1, 99999, 50000, 1'b0, 1'b0);
    sendRamp(28000, 3000, 2);
    idle(5);

    // sclr on the third sample drops the partial block.
    sendRamp(0, 2000, 2);
    applyStimulus(1'b1, 4000, 50000, 1'b1, 1'b1);
    sendRamp(6000, 500, 4);
    idle(5);

    // Randomized traffic with gaps, enable drops and occasional squelch.
    for (int k = 0; k < 120; k++) begin
      applyStimulus(1'($urandom_range(0, 3) != 0), int'($urandom),
                    int'($urandom_range(0, 4000)), 1'($urandom_range(0, 7) != 0), 1'b0);
    end
    idle(10);
    checkOutput("scoreboard_drained", sbq.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
